// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB3 requester: FSM state encoding,
// default bus widths and the response record captured at transfer end.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // The rdata field is sized for the package default data width.
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  slverr;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_if.sv
// Command/response stream plus APB3 bus signals for one requester.
// The master modport is the requester side; the slave modport is whatever
// drives commands and models the APB completer.
interface apb_master_if import apb_pkg::*; #(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_slverr;
    logic              rsp_timeout;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_master_wait_timer.sv
// Counts ACCESS cycles spent waiting for PREADY. The count saturates at
// TIMEOUT_CYCLES; expired flags the cycle whose wait would bring the count
// to TIMEOUT_CYCLES, so the abort lands on exactly that edge.
// TIMEOUT_CYCLES = 0 never expires.
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [CNT_W-1:0] count_q;

    // Wait counter: cleared on entry to ACCESS, advances per stalled cycle.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (count_q == CNT_LAST);

endmodule

// File: rtl/apb_master.sv
// APB3 requester: turns a valid/ready command stream into SETUP/ACCESS
// transfers and returns a single-cycle response per command.
//
// state  | meaning
// IDLE   | cmd_ready high, bus parked with last address/data held
// SETUP  | PSEL high, PENABLE low, one cycle
// ACCESS | PSEL and PENABLE high until PREADY or wait timeout
module apb_master import apb_pkg::*; #(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          PCLK,
    input  logic          PRESET,
    apb_master_if.master  bus
);

    apb_state_e        state_q;
    apb_state_e        state_d;
    logic              accept;
    logic              timer_clear;
    logic              timer_en;
    logic              timer_expired;

    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    apb_rsp_t          rsp_q;

    // cmd_ready is held low while reset is asserted.
    assign bus.cmd_ready = (state_q == IDLE) && !PRESET;
    assign accept        = bus.cmd_valid && (state_q == IDLE);

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    // State register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and timer control; PREADY completion wins over timeout.
    always_comb begin
        state_d     = state_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                timer_clear = 1'b1;
                state_d     = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    state_d = IDLE;
                end else begin
                    timer_en = 1'b1;
                    if (timer_expired) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered bus outputs and the one-cycle response record.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        psel_q   <= 1'b1;
                        pwrite_q <= bus.cmd_write;
                        paddr_q  <= bus.cmd_addr;
                        pwdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_q.rdata  <= pwrite_q ? '0 : APB_DATA_W'(bus.PRDATA);
                        rsp_q.slverr <= bus.PSLVERR;
                    end else if (timer_expired) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_q.slverr  <= 1'b1;
                        rsp_q.timeout <= 1'b1;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = DATA_W'(rsp_q.rdata);
    assign bus.rsp_slverr  = rsp_q.slverr;
    assign bus.rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed cases then random commands against a
// word-memory reference model and a scripted APB completer.
module tb_apb_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic pclk   = 1'b0;
    logic preset = 1'b1;

    always #5 pclk = ~pclk;

    apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PCLK   (pclk),
        .PRESET (preset),
        .bus    (bus)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // Issue one command from a negedge with the completer inserting `waits`
    // wait states (or never answering when hang=1); returns at a negedge.
    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic serr, input logic hang);
        logic [31:0] exp_rdata;
        logic        exp_serr;
        int          exp_edges;
        int          exp_acc;
        int          edges;
        int          acc;
        int          setup;
        logic        got;
        logic        hold_ok;
        logic        rdy_ok;
        logic        rdy;

        exp_serr  = hang ? 1'b1 : serr;
        exp_rdata = (wr || hang) ? 32'h0 : ref_rd(addr);
        exp_edges = hang ? TMO + 1 : waits + 2;
        exp_acc   = hang ? TMO : waits + 1;
        if (wr && !serr && !hang) ref_mem[addr] = wdata;

        check("ready_idle", 64'(bus.cmd_ready), 64'(1));
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        @(posedge pclk);
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;

        edges = 0; acc = 0; setup = 0; got = 1'b0; hold_ok = 1'b1; rdy_ok = 1'b1;
        while (!got && edges < 40) begin
            if (bus.PSEL && !bus.PENABLE) setup++;
            if (bus.cmd_ready && bus.PSEL) rdy_ok = 1'b0;
            if (bus.PSEL && (bus.PADDR !== addr || bus.PWRITE !== wr ||
                             bus.PWDATA !== (wr ? wdata : 32'h0))) hold_ok = 1'b0;
            if (bus.PSEL && bus.PENABLE) begin
                acc++;
                rdy           = !hang && (acc > waits);
                bus.PREADY    = rdy;
                bus.PSLVERR   = rdy ? serr : 1'($urandom);
                bus.PRDATA    = rdy ? slv_rd(bus.PADDR) : $urandom;
                if (rdy && bus.PWRITE && !serr) slave_mem[bus.PADDR] = bus.PWDATA;
            end else begin
                bus.PREADY  = 1'($urandom);
                bus.PSLVERR = 1'($urandom);
                bus.PRDATA  = $urandom;
            end
            @(posedge pclk);
            edges++;
            @(negedge pclk);
            if (bus.rsp_valid) got = 1'b1;
        end

        check("rsp_seen", 64'(got), 64'(1));
        check("latency", 64'(edges), 64'(exp_edges));
        check("setup_cycles", 64'(setup), 64'(1));
        check("access_cycles", 64'(acc), 64'(exp_acc));
        check("addr_hold", 64'(hold_ok), 64'(1));
        check("ready_busy", 64'(rdy_ok), 64'(1));
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rdata));
        check("rsp_slverr", 64'(bus.rsp_slverr), 64'(exp_serr));
        check("rsp_timeout", 64'(bus.rsp_timeout), 64'(hang));
        check("psel_drop", 64'(bus.PSEL), 64'(0));
        check("penable_drop", 64'(bus.PENABLE), 64'(0));
        check("ready_after", 64'(bus.cmd_ready), 64'(1));
        check("paddr_parked", 64'(bus.PADDR), 64'(addr));

        bus.PREADY  = 1'($urandom);
        bus.PSLVERR = 1'($urandom);
        @(posedge pclk);
        @(negedge pclk);
        check("rsp_pulse", 64'(bus.rsp_valid), 64'(0));
        check("slverr_clr", 64'(bus.rsp_slverr), 64'(0));
        check("timeout_clr", 64'(bus.rsp_timeout), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        rst_seen;
        logic [31:0] a;

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        bus.PRDATA    = '0;

        repeat (2) @(negedge pclk);
        check("rst_psel", 64'(bus.PSEL), 64'(0));
        check("rst_penable", 64'(bus.PENABLE), 64'(0));
        check("rst_pwrite", 64'(bus.PWRITE), 64'(0));
        check("rst_paddr", 64'(bus.PADDR), 64'(0));
        check("rst_pwdata", 64'(bus.PWDATA), 64'(0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_rsp_flags", 64'({bus.rsp_slverr, bus.rsp_timeout}), 64'(0));
        check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
        check("rst_ready", 64'(bus.cmd_ready), 64'(0));
        preset = 1'b0;
        #1;
        check("ready_release", 64'(bus.cmd_ready), 64'(1));
        @(negedge pclk);

        slave_mem[32'h14] = 32'hCAFEF00D;
        ref_mem[32'h14]   = 32'hCAFEF00D;
        run_cmd(1'b1, 32'h10,  32'hDEADBEEF, 0, 1'b0, 1'b0);
        run_cmd(1'b0, 32'h14,  32'h0,        2, 1'b0, 1'b0);
        run_cmd(1'b1, 32'hFFC, 32'h12345678, 0, 1'b1, 1'b0);
        run_cmd(1'b0, 32'hFFC, 32'h0,        0, 1'b1, 1'b0);
        run_cmd(1'b0, 32'h20,  32'h0,        0, 1'b0, 1'b1);
        run_cmd(1'b0, 32'h10,  32'h0,        1, 1'b0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            a = 32'($urandom_range(0, 7)) * 32'd4;
            run_cmd(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 4)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        end

        // Reset in the middle of ACCESS.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h40;
        bus.cmd_wdata = 32'h5A5A1234;
        bus.PREADY    = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        check("rst_mid_in_access", 64'({bus.PSEL, bus.PENABLE}), 64'(3));
        #2 preset = 1'b1;
        #1;
        check("rst_mid_psel", 64'(bus.PSEL), 64'(0));
        check("rst_mid_penable", 64'(bus.PENABLE), 64'(0));
        check("rst_mid_ready", 64'(bus.cmd_ready), 64'(0));
        rst_seen = bus.rsp_valid;
        repeat (2) begin
            @(negedge pclk);
            rst_seen = rst_seen | bus.rsp_valid;
        end
        preset = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            rst_seen = rst_seen | bus.rsp_valid;
        end
        check("rst_mid_no_rsp", 64'(rst_seen), 64'(0));
        check("rst_mid_paddr", 64'(bus.PADDR), 64'(0));
        run_cmd(1'b0, 32'h40, 32'h0, 0, 1'b0, 1'b0);
        run_cmd(1'b1, 32'h40, 32'h0BADF00D, 1, 1'b0, 1'b0);
        run_cmd(1'b0, 32'h40, 32'h0, 0, 1'b0, 1'b0);

        // Back-to-back commands held on cmd_valid, zero-wait completer.
        begin : b2b
            logic        b_wr  [4];
            logic [31:0] b_ad  [4];
            logic [31:0] b_wd  [4];
            logic [31:0] b_exp [4];
            int          acc_t [$];
            logic [31:0] rsp_q [$];
            int          cyc;
            int          idx;
            int          guard;
            int          rdy_bad;
            logic        take;

            b_wr[0] = 1'b1; b_ad[0] = 32'h0;
            b_wr[1] = 1'b0; b_ad[1] = 32'h0;
            b_wr[2] = 1'b1; b_ad[2] = 32'h4;
            b_wr[3] = 1'b0; b_ad[3] = 32'h4;
            for (int k = 0; k < 4; k++) begin
                b_wd[k] = $urandom;
                if (b_wr[k]) begin
                    ref_mem[b_ad[k]] = b_wd[k];
                    b_exp[k] = 32'h0;
                end else begin
                    b_exp[k] = ref_rd(b_ad[k]);
                end
            end

            cyc = 0; idx = 0; guard = 0; rdy_bad = 0;
            bus.PREADY  = 1'b1;
            bus.PSLVERR = 1'b0;
            while ((idx < 4 || rsp_q.size() < 4) && guard < 80) begin
                if (bus.cmd_ready === bus.PSEL) rdy_bad++;
                if (idx < 4) begin
                    bus.cmd_valid = 1'b1;
                    bus.cmd_write = b_wr[idx];
                    bus.cmd_addr  = b_ad[idx];
                    bus.cmd_wdata = b_wd[idx];
                end else begin
                    bus.cmd_valid = 1'b0;
                end
                if (bus.PSEL && bus.PENABLE) begin
                    bus.PRDATA = slv_rd(bus.PADDR);
                    if (bus.PWRITE) slave_mem[bus.PADDR] = bus.PWDATA;
                end else begin
                    bus.PRDATA = $urandom;
                end
                take = (idx < 4) && bus.cmd_ready;
                @(posedge pclk);
                cyc++;
                if (take) begin
                    acc_t.push_back(cyc);
                    idx++;
                end
                @(negedge pclk);
                guard++;
                if (bus.rsp_valid) rsp_q.push_back(bus.rsp_rdata);
            end
            bus.cmd_valid = 1'b0;

            check("b2b_accepts", 64'(acc_t.size()), 64'(4));
            check("b2b_rsps", 64'(rsp_q.size()), 64'(4));
            check("b2b_ready_only_idle", 64'(rdy_bad), 64'(0));
            for (int k = 1; k < 4; k++) begin
                if (acc_t.size() > k) check("b2b_spacing", 64'(acc_t[k] - acc_t[k-1]), 64'(3));
            end
            for (int k = 0; k < 4; k++) begin
                if (rsp_q.size() > k) check("b2b_rdata", 64'(rsp_q[k]), 64'(b_exp[k]));
            end
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
